hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Decode-stage interlock controller, complementary to the EX-stage forwarding unit. Forwarding resolves operand hazards by supplying values; this block resolves the hazards forwarding cannot cover, by holding or flushing the pipeline.
- Covers three cases: load-use hazards, taken-branch flushes, and multi-cycle data-memory waits.
- Drives the PC and pipeline-register write enables and bubble/flush controls.
- Keeps a small FSM, a memory-wait timeout counter and saturating performance counters.

Parameters:
- MEM_WAIT_MAX, 16: maximum consecutive cycles in MEM_WAIT before mem_timeout is raised.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous, active-low reset
- mem_read_dx  in  1  instruction in ID/EX is a load
- rd_register_dx  in  5  destination register of the ID/EX instruction
- rs_register_fd  in  5  rs field of the IF/ID instruction
- rt_register_fd  in  5  rt field of the IF/ID instruction
- uses_rt_fd  in  1  IF/ID instruction reads rt (0 for I-type, where rt is the destination)
- branch_taken_dx  in  1  branch resolved taken in EX
- dmem_req_xm  in  1  EX/MEM instruction accesses data memory
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC update enable
- fd_write  out  1  IF/ID register write enable
- fd_flush  out  1  zero the IF/ID register
- dx_bubble  out  1  load a NOP into ID/EX
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB
- mem_timeout  out  1  sticky error flag
- stall_cycles  out  CNT_W  count of cycles with pc_write=0
- flush_count  out  CNT_W  count of taken-branch flushes

Behaviour:
- Clocking and reset: single clock domain. All state updates on the rising edge of clk.
- rst_n=0 at an edge:
  - state returns to RUN.
  - wait_cnt, stall_cycles, flush_count and mem_timeout are cleared.
  - This applies mid-operation as well, including during MEM_WAIT.
- Outputs are combinational from the registered state and the current inputs. There is no added latency.
- Default outputs: pc_write=1, fd_write=1, fd_flush=0, dx_bubble=0, pipe_freeze=0.
- Load-use hazard (lu) is asserted when all of these hold:
  - mem_read_dx=1
  - rd_register_dx != 0
  - rd_register_dx == rs_register_fd, or (uses_rt_fd=1 and rd_register_dx == rt_register_dx's match against rt_register_fd, i.e. rd_register_dx == rt_register_fd)
- mw (memory wait) is asserted when dmem_req_xm=1 and dmem_ready=0.
- Priority within any cycle: mw > branch_taken_dx > lu.
- FSM states: RUN, LU_STALL, MEM_WAIT.
- RUN:
  - If mw: pipe_freeze=1, pc_write=0, fd_write=0. Next state MEM_WAIT, wait_cnt=1.
  - Else if branch_taken_dx: fd_flush=1, dx_bubble=1; flush_count increments. Stays in RUN.
  - Else if lu: pc_write=0, fd_write=0, dx_bubble=1. Next state LU_STALL.
- LU_STALL:
  - Lasts exactly one cycle; ID/EX now holds the bubble.
  - Default outputs apply, except that mw or branch_taken_dx are handled exactly as in RUN.
  - A new lu is not re-raised in this state, so no double bubble is inserted.
  - Next state RUN, or MEM_WAIT if mw.
- MEM_WAIT:
  - While mw holds: pipe_freeze=1, pc_write=0, fd_write=0, and wait_cnt increments, saturating at MEM_WAIT_MAX.
  - When wait_cnt reaches MEM_WAIT_MAX while still waiting, mem_timeout is set. It stays set until reset.
  - On dmem_ready=1: outputs revert to the defaults that cycle and the next state is RUN.
  - branch_taken_dx and lu are evaluated on the release cycle with normal priority.
- stall_cycles increments every cycle pc_write=0. It saturates at all-ones, as does flush_count.
- Register-0 rule: rd_register_dx=0 never causes a stall.

Decomposition:
- Shared package holds:
  - a state enum: RUN=2'd0, LU_STALL=2'd1, MEM_WAIT=2'd2
  - a REG_ZERO constant (5'd0)
  - the register-index width REG_W=5, reused by the forwarding unit
- One natural sub-module, sat_counter (parameterised width, increment enable, synchronous active-low clear), instantiated for stall_cycles and flush_count.

Test Plan:
- lw $2 in ID/EX, add $3,$2,$4 in IF/ID -> for one cycle pc_write=0, fd_write=0, dx_bubble=1; next cycle all defaults; stall_cycles=1.
- lw $0 in ID/EX, add reading $0 -> no stall. I-type with uses_rt_fd=0 and rt=rd_register_dx=5 -> no stall.
- dmem_req_xm=1, dmem_ready low for 3 cycles -> pipe_freeze=1 for 3 cycles, release on the ready cycle, stall_cycles=3.
- MEM_WAIT_MAX=4, ready held low for 6 cycles -> mem_timeout=1 from the 4th wait cycle; it stays 1 after ready rises, and clears only on rst_n=0.
- branch_taken_dx and lu in the same cycle -> fd_flush=1, dx_bubble=1, pc_write=1, flush_count=1, no LU_STALL entry.
- rst_n=0 asserted during MEM_WAIT -> next edge returns to RUN, all outputs at defaults, counters=0.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// Shared decode-interlock definitions: FSM encoding and register-index constants.
// REG_W is also consumed by the EX-stage forwarding unit.
package hazard_stall_unit_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hsu_state_e;

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (!clr_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Decode-stage interlock: load-use stalls, taken-branch flushes and data-memory waits.
// Priority each cycle is memory wait, then taken branch, then load-use.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read_dx,
    input  logic [REG_W-1:0] rd_register_dx,
    input  logic [REG_W-1:0] rs_register_fd,
    input  logic [REG_W-1:0] rt_register_fd,
    input  logic             uses_rt_fd,
    input  logic             branch_taken_dx,
    input  logic             dmem_req_xm,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             fd_write,
    output logic             fd_flush,
    output logic             dx_bubble,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WC_W = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_WAIT_MAX);

    hsu_state_e      state_q, state_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            timeout_q, timeout_d;
    logic            lu, mw;

    assign lu = mem_read_dx && (rd_register_dx != REG_ZERO) &&
                ((rd_register_dx == rs_register_fd) ||
                 (uses_rt_fd && (rd_register_dx == rt_register_fd)));
    assign mw = dmem_req_xm && !dmem_ready;

    // MEM_WAIT release and LU_STALL fall through to RUN handling; only LU_STALL masks lu
    // so the bubble already sitting in ID/EX is not doubled.
    always_comb begin
        pc_write    = 1'b1;
        fd_write    = 1'b1;
        fd_flush    = 1'b0;
        dx_bubble   = 1'b0;
        pipe_freeze = 1'b0;
        state_d     = RUN;
        wait_cnt_d  = '0;
        timeout_d   = timeout_q;
        if (mw) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            fd_write    = 1'b0;
            state_d     = MEM_WAIT;
            if (state_q == MEM_WAIT)
                wait_cnt_d = (wait_cnt_q >= WC_MAX) ? WC_MAX : wait_cnt_q + WC_W'(1);
            else
                wait_cnt_d = WC_W'(1);
            // Flag lands at the edge closing the MEM_WAIT_MAX-th consecutive wait cycle.
            if (wait_cnt_d >= WC_MAX)
                timeout_d = 1'b1;
        end else if (branch_taken_dx) begin
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
        end else if (lu && (state_q != LU_STALL)) begin
            pc_write  = 1'b0;
            fd_write  = 1'b0;
            dx_bubble = 1'b1;
            state_d   = LU_STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .clr_n_i (rst_n),
        .inc_i   (!pc_write),
        .cnt_o   (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .clr_n_i (rst_n),
        .inc_i   (fd_flush),
        .cnt_o   (flush_count)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with a short wait limit and narrow counters.
module tb_hazard_stall_unit;

    localparam int MWMAX = 4;
    localparam int CW    = 4;
    // {pc_write, fd_write, fd_flush, dx_bubble, pipe_freeze}
    localparam logic [4:0] DEF = 5'b11000;
    localparam logic [4:0] LUS = 5'b00010;
    localparam logic [4:0] FRZ = 5'b00001;
    localparam logic [4:0] BRF = 5'b11110;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_read_dx, uses_rt_fd, branch_taken_dx, dmem_req_xm, dmem_ready;
    logic [4:0]    rd_register_dx, rs_register_fd, rt_register_fd;
    logic          pc_write, fd_write, fd_flush, dx_bubble, pipe_freeze, mem_timeout;
    logic [CW-1:0] stall_cycles, flush_count;
    logic [4:0]    ctl;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.MEM_WAIT_MAX(MWMAX), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read_dx(mem_read_dx), .rd_register_dx(rd_register_dx),
        .rs_register_fd(rs_register_fd), .rt_register_fd(rt_register_fd),
        .uses_rt_fd(uses_rt_fd), .branch_taken_dx(branch_taken_dx),
        .dmem_req_xm(dmem_req_xm), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .fd_write(fd_write), .fd_flush(fd_flush),
        .dx_bubble(dx_bubble), .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    assign ctl = {pc_write, fd_write, fd_flush, dx_bubble, pipe_freeze};

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        mem_read_dx = 0; rd_register_dx = 0; rs_register_fd = 0; rt_register_fd = 0;
        uses_rt_fd = 0; branch_taken_dx = 0; dmem_req_xm = 0; dmem_ready = 1;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urt);
        mem_read_dx = 1; rd_register_dx = rd; rs_register_fd = rs;
        rt_register_fd = rt; uses_rt_fd = urt;
    endtask

    // Check this cycle's controls, clock once, then check the counters.
    task automatic step(input string tag, input logic [4:0] exp_ctl);
        #1;
        chk(tag, 16'(ctl), 16'(exp_ctl));
        if (!exp_ctl[4]) exp_stall = (exp_stall == 15) ? 15 : exp_stall + 1;
        if (exp_ctl[2])  exp_flush = (exp_flush == 15) ? 15 : exp_flush + 1;
        @(posedge clk); #1;
        chk({tag, "_stall"}, 16'(stall_cycles), 16'(exp_stall));
        chk({tag, "_flush"}, 16'(flush_count), 16'(exp_flush));
    endtask

    initial begin
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        #1;
        chk("rst_ctl", 16'(ctl), 16'(DEF));
        chk("rst_stall", 16'(stall_cycles), 16'd0);
        chk("rst_flush", 16'(flush_count), 16'd0);
        chk("rst_to", 16'(mem_timeout), 16'd0);

        // load-use on rs; inputs held in LU_STALL must not re-bubble
        set_lu(5'd2, 5'd2, 5'd4, 1'b1);
        step("lu_rs", LUS);
        step("lu_hold", DEF);
        idle();
        step("lu_after", DEF);
        // load-use on rt
        set_lu(5'd7, 5'd1, 5'd7, 1'b1);
        step("lu_rt", LUS);
        idle();
        step("lu_rt_st", DEF);
        // no-stall cases
        set_lu(5'd0, 5'd0, 5'd0, 1'b1);
        step("r0", DEF);
        set_lu(5'd5, 5'd1, 5'd5, 1'b0);
        step("itype", DEF);
        set_lu(5'd5, 5'd5, 5'd5, 1'b1);
        mem_read_dx = 0;
        step("noload", DEF);

        // 3-cycle memory wait then release
        idle();
        dmem_req_xm = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) step("mw3", FRZ);
        dmem_ready = 1;
        step("mw_rel", DEF);
        chk("mw_to", 16'(mem_timeout), 16'd0);
        idle();

        // branch beats load-use; stays in RUN so lu stalls next cycle
        set_lu(5'd3, 5'd3, 5'd0, 1'b0);
        branch_taken_dx = 1;
        step("br_lu", BRF);
        branch_taken_dx = 0;
        step("lu_post_br", LUS);
        idle();
        step("lu_st2", DEF);
        branch_taken_dx = 1;
        step("br_only", BRF);
        idle();

        // lu evaluated on the release cycle; mw wins in LU_STALL
        dmem_req_xm = 1; dmem_ready = 0;
        step("mw1", FRZ);
        dmem_ready = 1;
        set_lu(5'd9, 5'd9, 5'd0, 1'b0);
        step("rel_lu", LUS);
        dmem_ready = 0;
        step("lust_mw", FRZ);
        idle();
        step("lust_rel", DEF);

        // timeout at the 4th wait cycle; stall counter saturates
        dmem_req_xm = 1; dmem_ready = 0;
        for (int k = 1; k <= 9; k++) begin
            step("to_frz", FRZ);
            chk($sformatf("to_%0d", k), 16'(mem_timeout), 16'(k >= MWMAX));
        end
        dmem_ready = 1;
        step("to_rel", DEF);
        chk("to_sticky", 16'(mem_timeout), 16'd1);
        idle();
        step("to_idle", DEF);
        chk("to_sticky2", 16'(mem_timeout), 16'd1);

        // reset in the middle of MEM_WAIT
        dmem_req_xm = 1; dmem_ready = 0;
        step("pre_rst1", FRZ);
        step("pre_rst2", FRZ);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        exp_stall = 0; exp_flush = 0;
        chk("mrst_stall", 16'(stall_cycles), 16'd0);
        chk("mrst_flush", 16'(flush_count), 16'd0);
        chk("mrst_to", 16'(mem_timeout), 16'd0);
        for (int k = 1; k <= 4; k++) begin
            step("mrst_frz", FRZ);
            chk($sformatf("mrst_to_%0d", k), 16'(mem_timeout), 16'(k >= MWMAX));
        end
        idle();
        step("mrst_def", DEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
